// File: rtl/patch_sweep_pkg.sv
// Shared types and sizing helpers for the ECO patch truth-table sweeper.
package patch_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int DEF_SETTLE = 1;

  function automatic int num_vectors(input int n_in);
    return 1 << n_in;
  endfunction

  // Width of the settle down-counter: it must hold SETTLE-1, never less than one bit.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/patch_sweep_settle_cnt.sv
// Loadable down-counter that paces how long each vector is held before sampling.
module patch_sweep_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/patch_sweep_ctrl.sv
// Exhaustive input sweeper for a combinational ECO patch: drives every vector,
// compares the patch output against a latched golden truth table, reports results.
module patch_sweep_ctrl
  import patch_sweep_pkg::*;
#(
  parameter int N_IN         = 3,
  parameter int SETTLE       = DEF_SETTLE,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [num_vectors(N_IN)-1:0]  golden_tt,
  output logic [N_IN-1:0]               vec_out,
  input  logic                          patch_t0,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 mis_cnt,
  output logic [N_IN-1:0]               first_fail,
  output logic [1:0]                    dbg_state
);

  localparam int NV = num_vectors(N_IN);
  localparam int CW = settle_cnt_w(SETTLE);
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN:0]   MIS_MAX     = (N_IN + 1)'(NV);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;

  sweep_state_t    state_q;
  logic [NV-1:0]   golden_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   mis_cnt_q;
  logic [N_IN-1:0] first_fail_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic accept;
  logic mismatch;
  logic sweep_end;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // The cycle carrying the done pulse still counts as busy, so start is only
  // accepted once that pulse has dropped.
  assign accept    = (state_q == ST_IDLE) && start && !done_q;
  // Case inequality: an X from the patch must never compare equal.
  assign mismatch  = (patch_t0 !== golden_q[vec_q]);
  assign sweep_end = (vec_q == LAST_VEC) || (mismatch && STOP_ON_FAIL);
  assign cnt_load  = accept || ((state_q == ST_SAMPLE) && !sweep_end);
  assign cnt_dec   = (state_q == ST_DRIVE);

  patch_sweep_settle_cnt #(
    .W (CW)
  ) u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      golden_q     <= '0;
      vec_q        <= '0;
      mis_cnt_q    <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            golden_q     <= golden_tt;
            vec_q        <= '0;
            mis_cnt_q    <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_DRIVE;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (cnt_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (mis_cnt_q != MIS_MAX) begin
              mis_cnt_q <= mis_cnt_q + 1'b1;
            end
            if (mis_cnt_q == '0) begin
              first_fail_q <= vec_q;
            end
          end
          if (sweep_end) begin
            state_q <= ST_DONE;
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          // mis_cnt_q already includes the final sample here.
          done_q  <= 1'b1;
          pass_q  <= (mis_cnt_q == '0);
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign mis_cnt    = mis_cnt_q;
  assign first_fail = first_fail_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_patch_sweep_ctrl.sv
// Bench for patch_sweep_ctrl: directed scenarios plus random truth tables,
// with results predicted from a vector-by-vector model of the sweep.
module tb_patch_sweep_ctrl;

  localparam int N_IN   = 3;
  localparam int NV     = 8;
  localparam int SETTLE = 1;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic [7:0] golden0, golden1;
  logic [7:0] patch_tt0, patch_tt1;

  logic [2:0] vec0, vec1;
  logic       p0, p1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [3:0] mis0, mis1;
  logic [2:0] ff0, ff1;
  logic [1:0] st0, st1;

  int n_cmp;
  int n_fail;

  assign p0 = patch_tt0[vec0];
  assign p1 = patch_tt1[vec1];

  patch_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start0), .golden_tt(golden0), .vec_out(vec0),
    .patch_t0(p0), .busy(busy0), .done(done0), .pass(pass0), .mis_cnt(mis0),
    .first_fail(ff0), .dbg_state(st0)
  );

  patch_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE), .STOP_ON_FAIL(1'b1)) dut_stop (
    .clk(clk), .rst(rst), .start(start1), .golden_tt(golden1), .vec_out(vec1),
    .patch_t0(p1), .busy(busy1), .done(done1), .pass(pass1), .mis_cnt(mis1),
    .first_fail(ff1), .dbg_state(st1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the vectors in order, stop early only when asked to.
  function automatic void ref_sweep(input logic [7:0] g, input logic [7:0] p, input bit stop,
                                    output int mis, output int ff, output int last,
                                    output int done_edge);
    bit halted;
    mis = 0; ff = 0; last = NV - 1; halted = 0;
    for (int v = 0; v < NV; v++) begin
      if (!halted && (g[v] != p[v])) begin
        if (mis == 0) ff = v;
        mis++;
        if (stop) begin
          last = v;
          halted = 1;
        end
      end
    end
    if (mis > NV) mis = NV;
    done_edge = (last + 1) * (SETTLE + 1) + 1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec0"},  vec0, 0);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_pass0"}, pass0, 0);
    chk({tag, "_mis0"},  mis0, 0);
    chk({tag, "_ff0"},   ff0, 0);
    chk({tag, "_st0"},   st0, 0);
    chk({tag, "_vec1"},  vec1, 0);
    chk({tag, "_mis1"},  mis1, 0);
    chk({tag, "_busy1"}, busy1, 0);
  endtask

  // Driver: one sweep on the selected DUT, edge 0 is the edge that samples start.
  task automatic run_sweep(input string tag, input bit sel, input logic [7:0] g,
                           input logic [7:0] p, input bit chk_seq);
    int mis, ff, last, de, e, done_at;
    logic [2:0] v;
    ref_sweep(g, p, sel, mis, ff, last, de);
    @(negedge clk);
    if (sel) begin golden1 = g; patch_tt1 = p; start1 = 1'b1; end
    else     begin golden0 = g; patch_tt0 = p; start0 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    golden0 = ~g; golden1 = ~g;
    chk({tag, "_busy_after_accept"}, sel ? busy1 : busy0, 1);
    e = 0; done_at = -1;
    while (done_at < 0 && e < 200) begin
      v = sel ? vec1 : vec0;
      if (chk_seq && e < NV * (SETTLE + 1)) chk({tag, "_vec_seq"}, v, e / (SETTLE + 1));
      if (sel ? done1 : done0) done_at = e;
      else begin
        @(posedge clk); e++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_edge"}, done_at, de);
    chk({tag, "_mis_cnt"}, sel ? mis1 : mis0, mis);
    chk({tag, "_first_fail"}, sel ? ff1 : ff0, ff);
    chk({tag, "_pass"}, sel ? pass1 : pass0, (mis == 0) ? 1 : 0);
    chk({tag, "_vec_final"}, sel ? vec1 : vec0, last);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, sel ? done1 : done0, 0);
    chk({tag, "_busy_dropped"}, sel ? busy1 : busy0, 0);
    chk({tag, "_mis_held"}, sel ? mis1 : mis0, mis);
    chk({tag, "_pass_held"}, sel ? pass1 : pass0, (mis == 0) ? 1 : 0);
  endtask

  initial begin
    int dq[$];
    int cnt, guard;
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    golden0 = 8'h00; golden1 = 8'h00; patch_tt0 = 8'hE8; patch_tt1 = 8'hE8;
    #2 rst = 1'b1;
    #1 chk_reset_vals("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset_release");

    // Directed scenarios
    run_sweep("majority", 0, 8'hE8, 8'hE8, 1);
    run_sweep("vec0_bad", 0, 8'hE9, 8'hE8, 1);
    run_sweep("stop_first", 1, 8'h17, 8'hE8, 0);
    run_sweep("all_bad", 0, 8'h17, 8'hE8, 1);
    run_sweep("stop_none", 1, 8'hE8, 8'hE8, 1);

    // Start held high: back-to-back sweeps, DONE cycle ignores start.
    @(negedge clk);
    golden0 = 8'hE8; patch_tt0 = 8'hE8; start0 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) dq.push_back(e);
    end
    start0 = 1'b0;
    chk("held_done_count", dq.size(), 2);
    if (dq.size() >= 2) begin
      chk("held_done_1", dq[0], 17);
      chk("held_done_2", dq[1], 36);
    end
    guard = 0;
    while (busy0 && guard < 100) begin @(negedge clk); guard++; end
    chk("held_drain", busy0, 0);

    // Reset in the middle of a sweep, while vector 4 is being driven.
    @(negedge clk);
    golden0 = 8'hE8; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    chk("midrst_vec_before", vec0, 4);
    chk("midrst_state_before", st0, 1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    chk("midrst_idle_vec", vec0, 0);
    run_sweep("after_rst", 0, 8'hE8, 8'hE8, 1);

    // Random truth tables against random patches on either DUT.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] g, p;
      bit sel;
      g = 8'($urandom_range(0, 255));
      p = (i % 3 == 0) ? g : 8'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      run_sweep("random", sel, g, p, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/patch_sweep_ctrl.md
Name: patch_sweep_ctrl

Overview:
- Sequencer that exhaustively drives all 2^N_IN input vectors into a combinational ECO patch netlist.
- Waits a programmable settle time per vector, then samples the patch output and compares it against a golden truth table latched at start.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits between the ECO verification harness and the patch instance; the patch stays purely combinational.

Parameters:
- N_IN, 3, number of patch inputs (1..8); vector space is 2^N_IN.
- SETTLE, 1, cycles each vector is held before sampling (must be >= 1).
- STOP_ON_FAIL, 0, 1 = terminate the sweep at the first mismatch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- golden_tt  in  2^N_IN  expected output; bit i is the expected value for vector i.
- vec_out  out  N_IN  drives patch inputs; bit 0 = first patch input (a), bit 1 = b, and so on.
- patch_t0  in  1  patch output t_0.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  result valid from done onward: 1 iff no mismatches.
- mis_cnt  out  N_IN+1  number of mismatching vectors.
- first_fail  out  N_IN  lowest failing vector index; 0 if none.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, vec_out=0, busy=0, done=0, pass=0, mis_cnt=0, first_fail=0, settle counter=0, golden register=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 latches golden_tt, sets vec_out=0, clears mis_cnt, first_fail and pass, loads settle counter with SETTLE-1, and moves to DRIVE.
  - start=0: stay.
- DRIVE:
  - vec_out is held stable.
  - Counter decrements each cycle; at 0 move to SAMPLE. DRIVE lasts exactly SETTLE cycles.
- SAMPLE:
  - mismatch = patch_t0 XOR golden_reg[vec_out].
  - On mismatch: mis_cnt increments (saturating at 2^N_IN, which is exactly representable); if this is the first mismatch, first_fail = vec_out.
  - If vec_out == 2^N_IN-1, or (mismatch and STOP_ON_FAIL=1): go to DONE with vec_out unchanged.
  - Otherwise: vec_out+1, reload counter with SETTLE-1, go to DRIVE.
  - vec_out never wraps during a sweep.
- DONE: done=1 for exactly one cycle; pass = (mis_cnt==0) including the final sample; next state IDLE.
- Result outputs (pass, mis_cnt, first_fail) hold until the next accepted start.
- Latency, full sweep without early stop: done is high in the cycle after edge number 2^N_IN*(SETTLE+1)+1, counting the edge that samples start as edge 0.
- start while busy is ignored, with no effect on the sweep. start in the DONE cycle is also ignored. start in the IDLE cycle immediately after DONE is accepted.
- golden_tt changes after acceptance have no effect.
- vec_out returns to 0 only on a new start or on reset; after DONE it holds the last vector.
- Reset mid-sweep aborts immediately to reset values. No done pulse is produced.
- Patch output containing X in simulation: the comparison is treated as a mismatch. Implement with case inequality so that X never silently passes.

Decomposition:
- Package patch_sweep_pkg holds:
  - state enum (IDLE, DRIVE, SAMPLE, DONE), 2-bit encoding;
  - a function returning 2^N_IN;
  - the localparam width of the settle counter, $clog2(SETTLE+1).
- One sub-module is natural: patch_sweep_settle_cnt, a loadable down-counter with a zero flag.
- FSM, vector counter and scoreboard stay in patch_sweep_ctrl.

Test Plan:
- N_IN=3, SETTLE=1, patch model = majority, golden_tt=8'hE8, pulse start → done in the cycle after edge 17, pass=1, mis_cnt=0, first_fail=0, vec_out sequence 0..7 each held 2 cycles.
- Same patch model, golden_tt=8'hE9 (vector 0 wrong), STOP_ON_FAIL=0 → pass=0, mis_cnt=1, first_fail=0, done after edge 17.
- golden_tt=8'h17 (inverse of majority), STOP_ON_FAIL=1 → sweep stops at vector 0, done in the cycle after edge 3, mis_cnt=1, first_fail=0, vec_out=0.
- golden_tt=8'h17, STOP_ON_FAIL=0 → mis_cnt=8, pass=0, first_fail=0; confirms the saturating width.
- Start held high for 40 cycles → exactly two sweeps: second accepted in the IDLE cycle after DONE, done pulses after edges 17 and 36.
- Assert rst for 1 cycle while vec_out=4 in DRIVE → all outputs go to reset values asynchronously, no done pulse; a following start runs a clean full sweep.
